ex_stage: RTL and testbench

//  Execute stage; consumes the decoded operation registered by the ID/EX buffer and produces the

---
 rtl/ex_stage_pkg.sv | 56 +++++
 rtl/ex_div.sv | 98 +++++++++
 rtl/ex_stage.sv | 174 +++++++++++++++++
 tb/tb_ex_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared constants for the execute stage.
// Holds the operation codes (EXE_*_OP), result-class selectors (EXE_RES_*),
// the divider state encoding and the divider ready flags.
package ex_stage_pkg;

    // Operation codes
    localparam logic [7:0] EXE_NOP_OP   = 8'h00;
    localparam logic [7:0] EXE_SRL_OP   = 8'h02;
    localparam logic [7:0] EXE_SRA_OP   = 8'h03;
    localparam logic [7:0] EXE_MFHI_OP  = 8'h10;
    localparam logic [7:0] EXE_MTHI_OP  = 8'h11;
    localparam logic [7:0] EXE_MFLO_OP  = 8'h12;
    localparam logic [7:0] EXE_MTLO_OP  = 8'h13;
    localparam logic [7:0] EXE_MULT_OP  = 8'h18;
    localparam logic [7:0] EXE_MULTU_OP = 8'h19;
    localparam logic [7:0] EXE_DIV_OP   = 8'h1A;
    localparam logic [7:0] EXE_DIVU_OP  = 8'h1B;
    localparam logic [7:0] EXE_ADD_OP   = 8'h20;
    localparam logic [7:0] EXE_ADDU_OP  = 8'h21;
    localparam logic [7:0] EXE_SUB_OP   = 8'h22;
    localparam logic [7:0] EXE_SUBU_OP  = 8'h23;
    localparam logic [7:0] EXE_AND_OP   = 8'h24;
    localparam logic [7:0] EXE_OR_OP    = 8'h25;
    localparam logic [7:0] EXE_XOR_OP   = 8'h26;
    localparam logic [7:0] EXE_NOR_OP   = 8'h27;
    localparam logic [7:0] EXE_SLT_OP   = 8'h2A;
    localparam logic [7:0] EXE_SLTU_OP  = 8'h2B;
    localparam logic [7:0] EXE_ADDI_OP  = 8'h55;
    localparam logic [7:0] EXE_ADDIU_OP = 8'h56;
    localparam logic [7:0] EXE_SLL_OP   = 8'h7C;
    localparam logic [7:0] EXE_MADD_OP  = 8'hA6;
    localparam logic [7:0] EXE_MADDU_OP = 8'hA8;
    localparam logic [7:0] EXE_MUL_OP   = 8'hA9;
    localparam logic [7:0] EXE_MSUB_OP  = 8'hAA;
    localparam logic [7:0] EXE_MSUBU_OP = 8'hAB;

    // Result classes
    localparam logic [2:0] EXE_RES_NOP        = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE       = 3'b011;
    localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;
    localparam logic [2:0] EXE_RES_MUL        = 3'b101;

    // Divider
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/ex_div.sv
// Restoring divider for DIV/DIVU.
// Ports: clk, rst (async, active-high); start_i (divide op present), signed_div_i,
// opdata1_i (dividend), opdata2_i (divisor), annul_i (op withdrawn), hold_i (freeze);
// result_o = {remainder, quotient}, valid while ready_o=1 (state DivEnd).
module ex_div
    import ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                signed_div_i,
    input  logic                annul_i,
    input  logic                hold_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    div_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    // [2W:W+1] partial remainder, [W:1] dividend bits still to consume / quotient
    // bits, [0] newest quotient bit.
    logic [2*DATA_W:0] dividend_q;
    logic [2*DATA_W:0] dividend_step;
    logic [DATA_W-1:0] divisor_q;
    logic              quo_neg_q;
    logic              rem_neg_q;
    logic [DATA_W-1:0] mag1, mag2, diff, quo, rem;
    logic [DATA_W:0]   partial;
    logic              ge;

    assign mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    assign partial = dividend_q[2*DATA_W:DATA_W];
    assign ge      = partial >= {1'b0, divisor_q};
    // When ge holds the difference is below the divisor, so W bits suffice.
    assign diff    = partial[DATA_W-1:0] - divisor_q;
    assign dividend_step = ge ? {diff, dividend_q[DATA_W-1:0], 1'b1}
                              : {dividend_q[2*DATA_W-1:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
        end else if (!hold_i) begin
            unique case (state_q)
                DivFree: begin
                    if (start_i && !annul_i) begin
                        cnt_q     <= '0;
                        quo_neg_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        rem_neg_q <= signed_div_i & opdata1_i[DATA_W-1];
                        if (opdata2_i == '0) begin
                            state_q <= DivByZero;
                        end else begin
                            state_q    <= DivOn;
                            dividend_q <= {{DATA_W{1'b0}}, mag1, 1'b0};
                            divisor_q  <= mag2;
                        end
                    end
                end
                DivByZero: begin
                    dividend_q <= '0;
                    quo_neg_q  <= 1'b0;
                    rem_neg_q  <= 1'b0;
                    state_q    <= DivEnd;
                end
                DivOn: begin
                    if (annul_i) begin
                        state_q <= DivFree;
                    end else begin
                        dividend_q <= dividend_step;
                        cnt_q      <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) state_q <= DivEnd;
                    end
                end
                DivEnd: state_q <= DivFree;
                default: state_q <= DivFree;
            endcase
        end
    end

    assign quo      = dividend_q[DATA_W-1:0];
    assign rem      = dividend_q[2*DATA_W:DATA_W+1];
    assign ready_o  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
    assign result_o = ready_o ? {(rem_neg_q ? -rem : rem), (quo_neg_q ? -quo : quo)} : '0;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/move/arith/multiply, two-phase MADD/MSUB and
// multi-cycle divide via ex_div.
// Ports: clk, rst (async, active-high); aluop_i/alusel_i decoded op; reg1_i/reg2_i operands;
// wd_i/wreg_i destination; hi_i/lo_i forwarded HI/LO; stall (bit 4 freezes state);
// wd_o/wreg_o/wdata_o register write; whilo_o/hi_o/lo_o HI/LO write; stallreq_o.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            aluop_i,
    input  logic [2:0]            alusel_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     hi_i,
    input  logic [DATA_W-1:0]     lo_i,
    input  logic [5:0]            stall,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  whilo_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  stallreq_o
);

    localparam int unsigned SH_W = $clog2(DATA_W);
    localparam int unsigned MSB  = DATA_W - 1;

    logic [DATA_W-1:0]   logic_res, shift_res, move_res, arith_res, reg2_mux, sum;
    logic [2*DATA_W-1:0] mul_a, mul_b, mul_res, product_q, hilo_acc, div_result;
    logic [SH_W-1:0]     sh;
    logic hold, is_sub, is_madd, is_msub, mul_signed, is_div, div_ready, phase_q, ov;
    logic unused_stall;

    assign hold         = stall[4];
    assign unused_stall = ^{stall[5], stall[3:0]};
    assign sh           = reg1_i[SH_W-1:0];

    assign is_sub     = (aluop_i == EXE_SUB_OP) || (aluop_i == EXE_SUBU_OP);
    assign is_madd    = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MADDU_OP) || is_msub;
    assign is_msub    = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
    assign mul_signed = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MUL_OP) ||
                        (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MSUB_OP);
    assign is_div     = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

    // One full-width multiplier shared by MULT(U), MUL and MADD/MSUB(U).
    assign mul_a    = mul_signed ? {{DATA_W{reg1_i[MSB]}}, reg1_i} : {{DATA_W{1'b0}}, reg1_i};
    assign mul_b    = mul_signed ? {{DATA_W{reg2_i[MSB]}}, reg2_i} : {{DATA_W{1'b0}}, reg2_i};
    assign mul_res  = mul_a * mul_b;
    assign hilo_acc = is_msub ? {hi_i, lo_i} - product_q : {hi_i, lo_i} + product_q;

    assign reg2_mux = is_sub ? -reg2_i : reg2_i;
    assign sum      = reg1_i + reg2_mux;

    always_comb begin
        ov = 1'b0;
        if (aluop_i == EXE_ADD_OP || aluop_i == EXE_ADDI_OP)
            ov = (reg1_i[MSB] == reg2_i[MSB]) && (sum[MSB] != reg1_i[MSB]);
        else if (aluop_i == EXE_SUB_OP)
            ov = (reg1_i[MSB] != reg2_i[MSB]) && (sum[MSB] != reg1_i[MSB]);
    end

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        move_res  = '0;
        arith_res = '0;
        case (aluop_i)
            EXE_AND_OP:  logic_res = reg1_i & reg2_i;
            EXE_OR_OP:   logic_res = reg1_i | reg2_i;
            EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
            EXE_SLL_OP:  shift_res = reg2_i << sh;
            EXE_SRL_OP:  shift_res = reg2_i >> sh;
            EXE_SRA_OP:  shift_res = $signed(reg2_i) >>> sh;
            EXE_MFHI_OP: move_res  = hi_i;
            EXE_MFLO_OP: move_res  = lo_i;
            EXE_SLT_OP:  arith_res = {{(DATA_W-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
            EXE_SLTU_OP: arith_res = {{(DATA_W-1){1'b0}}, reg1_i < reg2_i};
            EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP,
            EXE_SUB_OP, EXE_SUBU_OP: arith_res = sum;
            default: ;
        endcase
    end

    // MADD/MSUB: phase 0 latches the product and stalls, phase 1 writes HI/LO once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= 1'b0;
            product_q <= '0;
        end else if (!hold) begin
            if (is_madd && !phase_q) begin
                product_q <= mul_res;
                phase_q   <= 1'b1;
            end else begin
                phase_q <= 1'b0;
            end
        end
    end

    ex_div #(
        .DATA_W(DATA_W)
    ) u_ex_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (is_div),
        .signed_div_i(aluop_i == EXE_DIV_OP),
        .annul_i     (!is_div),
        .hold_i      (hold),
        .opdata1_i   (reg1_i),
        .opdata2_i   (reg2_i),
        .result_o    (div_result),
        .ready_o     (div_ready)
    );

    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = 1'b0;
        if (!rst) begin
            wd_o       = wd_i;
            wreg_o     = wreg_i & ~ov;
            stallreq_o = (is_madd & ~phase_q) | (is_div & ~div_ready);
            case (alusel_i)
                EXE_RES_LOGIC:      wdata_o = logic_res;
                EXE_RES_SHIFT:      wdata_o = shift_res;
                EXE_RES_MOVE:       wdata_o = move_res;
                EXE_RES_ARITHMETIC: wdata_o = arith_res;
                EXE_RES_MUL:        wdata_o = mul_res[DATA_W-1:0];
                default:            wdata_o = '0;
            endcase
            case (aluop_i)
                EXE_MTHI_OP: begin
                    whilo_o = 1'b1;
                    hi_o    = reg1_i;
                    lo_o    = lo_i;
                end
                EXE_MTLO_OP: begin
                    whilo_o = 1'b1;
                    hi_o    = hi_i;
                    lo_o    = reg1_i;
                end
                EXE_MULT_OP, EXE_MULTU_OP: begin
                    whilo_o      = 1'b1;
                    {hi_o, lo_o} = mul_res;
                end
                EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP: begin
                    if (phase_q) begin
                        whilo_o      = 1'b1;
                        {hi_o, lo_o} = hilo_acc;
                    end
                end
                EXE_DIV_OP, EXE_DIVU_OP: begin
                    if (div_ready) begin
                        whilo_o      = 1'b1;
                        {hi_o, lo_o} = div_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk, rst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1, reg2, hi_in, lo_in;
    logic [4:0]  wd;
    logic        wreg;
    logic [5:0]  stall;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    int checks   = 0;
    int failures = 0;

    ex_stage #(
        .DATA_W    (32),
        .REG_ADDR_W(5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .aluop_i   (aluop),
        .alusel_i  (alusel),
        .reg1_i    (reg1),
        .reg2_i    (reg2),
        .wd_i      (wd),
        .wreg_i    (wreg),
        .hi_i      (hi_in),
        .lo_i      (lo_in),
        .stall     (stall),
        .wd_o      (wd_o),
        .wreg_o    (wreg_o),
        .wdata_o   (wdata_o),
        .whilo_o   (whilo_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .stallreq_o(stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present an op at the falling edge and let combinational outputs settle.
    task automatic apply_op(input logic [7:0] op, input logic [2:0] sel,
                            input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        aluop  = op;
        alusel = sel;
        reg1   = a;
        reg2   = b;
        #1;
    endtask

    // Run a divide; cycle 0 is first presentation. Returns cycles until whilo_o
    // (0 on timeout), number of stallreq cycles and the HI/LO result.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int hold_at, input int hold_len,
                           output int lat, output int stall_cnt,
                           output logic [31:0] hi_r, output logic [31:0] lo_r);
        lat = 0;
        stall_cnt = 0;
        hi_r = '0;
        lo_r = '0;
        @(negedge clk);
        aluop  = op;
        alusel = EXE_RES_NOP;
        reg1   = a;
        reg2   = b;
        for (int c = 0; c < 100; c++) begin
            stall = (c >= hold_at && c < hold_at + hold_len) ? 6'b010000 : 6'b000000;
            #1;
            if (whilo_o) begin
                lat  = c + 1;
                hi_r = hi_o;
                lo_r = lo_o;
                break;
            end
            if (stallreq_o) stall_cnt++;
            @(negedge clk);
        end
        stall = '0;
        @(negedge clk);
        aluop = EXE_NOP_OP;
    endtask

    int          lat, scnt;
    logic [31:0] dh, dl;

    initial begin
        rst    = 1'b1;
        aluop  = EXE_OR_OP;
        alusel = EXE_RES_LOGIC;
        reg1   = 32'h0000FF00;
        reg2   = 32'h00F0F0F0;
        wd     = 5'd5;
        wreg   = 1'b1;
        hi_in  = '0;
        lo_in  = '0;
        stall  = '0;
        #1;
        check_eq("rst_wdata", 64'(wdata_o), 64'h0);
        check_eq("rst_wreg", 64'(wreg_o), 64'h0);
        check_eq("rst_wd", 64'(wd_o), 64'h0);
        check_eq("rst_stallreq", 64'(stallreq_o), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("or_wdata", 64'(wdata_o), 64'h00F0FFF0);
        check_eq("or_wreg", 64'(wreg_o), 64'h1);
        check_eq("or_wd", 64'(wd_o), 64'h5);
        check_eq("or_stallreq", 64'(stallreq_o), 64'h0);

        apply_op(EXE_AND_OP, EXE_RES_LOGIC, 32'h0000FF00, 32'h00F0F0F0);
        check_eq("and", 64'(wdata_o), 64'h0000F000);
        apply_op(EXE_SLL_OP, EXE_RES_SHIFT, 32'd4, 32'h1);
        check_eq("sll", 64'(wdata_o), 64'h10);
        apply_op(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h80000000);
        check_eq("srl", 64'(wdata_o), 64'h08000000);
        apply_op(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h80000000);
        check_eq("sra", 64'(wdata_o), 64'hF8000000);
        apply_op(EXE_SLT_OP, EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'h1);
        check_eq("slt", 64'(wdata_o), 64'h1);
        apply_op(EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'hFFFFFFFF, 32'h1);
        check_eq("sltu", 64'(wdata_o), 64'h0);

        apply_op(EXE_ADD_OP, EXE_RES_ARITHMETIC, 32'h7FFFFFFF, 32'h1);
        check_eq("add_ov_wreg", 64'(wreg_o), 64'h0);
        apply_op(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'h7FFFFFFF, 32'h1);
        check_eq("addu_wdata", 64'(wdata_o), 64'h80000000);
        check_eq("addu_wreg", 64'(wreg_o), 64'h1);
        apply_op(EXE_SUB_OP, EXE_RES_ARITHMETIC, 32'h80000000, 32'h1);
        check_eq("sub_ov_wreg", 64'(wreg_o), 64'h0);
        apply_op(EXE_SUBU_OP, EXE_RES_ARITHMETIC, 32'h80000000, 32'h1);
        check_eq("subu_wdata", 64'(wdata_o), 64'h7FFFFFFF);
        check_eq("subu_wreg", 64'(wreg_o), 64'h1);

        hi_in = 32'h00001234;
        lo_in = 32'h00000055;
        apply_op(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0);
        check_eq("mfhi", 64'(wdata_o), 64'h1234);
        apply_op(EXE_MTHI_OP, EXE_RES_NOP, 32'hAA, 32'h0);
        check_eq("mthi_whilo", 64'(whilo_o), 64'h1);
        check_eq("mthi_hilo", {hi_o, lo_o}, 64'h000000AA_00000055);
        check_eq("mthi_wdata", 64'(wdata_o), 64'h0);

        apply_op(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFFFFFE, 32'd3);
        check_eq("mult_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFA);
        check_eq("mult_whilo", 64'(whilo_o), 64'h1);
        apply_op(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFFFFFF, 32'd2);
        check_eq("multu_hilo", {hi_o, lo_o}, 64'h00000001_FFFFFFFE);

        // MADD: one stall cycle, then a single HI/LO write
        hi_in = 32'h0;
        lo_in = 32'h5;
        apply_op(EXE_MADD_OP, EXE_RES_NOP, 32'hFFFFFFFE, 32'd3);
        check_eq("madd_p0_stallreq", 64'(stallreq_o), 64'h1);
        check_eq("madd_p0_whilo", 64'(whilo_o), 64'h0);
        @(negedge clk);
        #1;
        check_eq("madd_p1_stallreq", 64'(stallreq_o), 64'h0);
        check_eq("madd_p1_whilo", 64'(whilo_o), 64'h1);
        check_eq("madd_p1_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFF);
        apply_op(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);
        check_eq("madd_after_whilo", 64'(whilo_o), 64'h0);

        hi_in = 32'h0;
        lo_in = 32'd10;
        apply_op(EXE_MSUB_OP, EXE_RES_NOP, 32'd2, 32'd3);
        check_eq("msub_p0_stallreq", 64'(stallreq_o), 64'h1);
        @(negedge clk);
        #1;
        check_eq("msub_p1_hilo", {hi_o, lo_o}, 64'h00000000_00000004);
        apply_op(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);

        // Divides
        run_div(EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 1000, 0, lat, scnt, dh, dl);
        check_eq("div_lat", 64'(lat), 64'd34);
        check_eq("div_stallcnt", 64'(scnt), 64'd33);
        check_eq("div_hilo", {dh, dl}, 64'hFFFFFFFF_FFFFFFFD);

        run_div(EXE_DIVU_OP, 32'd100, 32'd7, 1000, 0, lat, scnt, dh, dl);
        check_eq("divu_lat", 64'(lat), 64'd34);
        check_eq("divu_hilo", {dh, dl}, 64'h00000002_0000000E);

        run_div(EXE_DIV_OP, 32'd7, 32'hFFFFFFFE, 1000, 0, lat, scnt, dh, dl);
        check_eq("div_negdvs_hilo", {dh, dl}, 64'h00000001_FFFFFFFD);

        run_div(EXE_DIV_OP, 32'd5, 32'd0, 1000, 0, lat, scnt, dh, dl);
        check_eq("div0_lat", 64'(lat), 64'd3);
        check_eq("div0_stallcnt", 64'(scnt), 64'd2);
        check_eq("div0_hilo", {dh, dl}, 64'h0);

        run_div(EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 10, 5, lat, scnt, dh, dl);
        check_eq("div_hold_lat", 64'(lat), 64'd39);
        check_eq("div_hold_hilo", {dh, dl}, 64'hFFFFFFFF_FFFFFFFD);

        // Reset at divider count 10 (cycle 11 after presentation)
        apply_op(EXE_DIV_OP, EXE_RES_NOP, 32'hFFFFFFF9, 32'd2);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("divrst_stallreq", 64'(stallreq_o), 64'h0);
        check_eq("divrst_whilo", 64'(whilo_o), 64'h0);
        check_eq("divrst_hilo", {hi_o, lo_o}, 64'h0);
        @(negedge clk);
        aluop = EXE_NOP_OP;
        rst   = 1'b0;
        run_div(EXE_DIVU_OP, 32'd100, 32'd7, 1000, 0, lat, scnt, dh, dl);
        check_eq("divrst_next_lat", 64'(lat), 64'd34);
        check_eq("divrst_next_hilo", {dh, dl}, 64'h00000002_0000000E);

        // Flush mid-divide: no HI/LO write, divider free again
        apply_op(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        aluop = EXE_NOP_OP;
        #1;
        check_eq("annul_stallreq", 64'(stallreq_o), 64'h0);
        @(negedge clk);
        #1;
        check_eq("annul_whilo", 64'(whilo_o), 64'h0);
        run_div(EXE_DIVU_OP, 32'd100, 32'd7, 1000, 0, lat, scnt, dh, dl);
        check_eq("annul_next_lat", 64'(lat), 64'd34);
        check_eq("annul_next_hilo", {dh, dl}, 64'h00000002_0000000E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
